prog_loader: RTL

Boot-time program loader sitting directly upstream of the single-cycle RISC-V core's instruction memory. It receives a byte stream carrying a length header and little-endian 32-bit instruction words, and writes them sequentially into instruction memory from address 0. It holds the core in reset while loading and releases it once the image has been written. Benches and the FPGA top use it in place of a preinitialised ROM image.

---
 rtl/loader_pkg.sv | 17 +
 rtl/word_packer.sv | 49 ++++
 rtl/prog_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCheck,
    StRun,
    StErr
  } loader_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_BYTES      = 2;

endpackage

// File: rtl/word_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid_o pulses on the 4th byte
// together with the completed word on word_o.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;

  always_comb begin
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    word_valid_o = 1'b0;
    if (clr_i) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (push_i) begin
      // New byte enters at the top so byte 0 ends up in [7:0] after four shifts.
      shreg_d = {byte_i, shreg_q[31:8]};
      if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
        cnt_d        = '0;
        word_valid_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  assign word_o = shreg_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed image into instruction memory and holds the core in reset until done.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned SIZE       = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic                  BYTE_VALID,
  input  logic [7:0]            BYTE_DATA,
  output logic                  BYTE_READY,
  output logic                  IMEM_WE,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  output logic [SIZE-1:0]       IMEM_WDATA,
  output logic                  CORE_RESET_N,
  output logic                  DONE,
  output logic                  ERROR
);

  localparam logic [16:0] MaxWords = 17'(1) << ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e PostData = StCheck;
`else
  localparam loader_state_e PostData = StRun;
`endif

  loader_state_e         state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SIZE-1:0]       wdata_q, wdata_d;

  logic        byte_ready;
  logic        xfer;
  logic        push;
  logic        clr;
  logic        data_done;
  logic [15:0] n_hdr;
  logic        word_valid;
  logic [31:0] word;

  assign data_done  = (cnt_q == len_q);
  // Ready drops once all words are packed so no stray byte is taken while the last write lands.
  assign byte_ready = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StCheck) ||
                      ((state_q == StData) && !data_done);
  assign xfer       = BYTE_VALID && byte_ready;
  assign push       = xfer && (state_q == StData);
  assign n_hdr      = {BYTE_DATA, len_q[7:0]};

  word_packer u_word_packer (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .clr_i        (clr),
    .push_i       (push),
    .byte_i       (BYTE_DATA),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clr) begin
      csum_d = '0;
    end else if (push) begin
      csum_d = csum_q ^ BYTE_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    clr     = 1'b0;
    case (state_q)
      StIdle, StRun, StErr: begin
        if (START) begin
          state_d = StLenLo;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      StLenLo: begin
        if (xfer) begin
          len_d   = {8'h00, BYTE_DATA};
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_d = n_hdr;
          if ({1'b0, n_hdr} > MaxWords) begin
            state_d = StErr;
          end else if (n_hdr == 16'd0) begin
            state_d = PostData;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (word_valid) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = word;
          cnt_d   = cnt_q + 16'd1;
        end
        // Leave only after the final strobe so the core is released one cycle later.
        if (data_done && we_q) begin
          state_d = PostData;
        end
      end
      StCheck: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) begin
          state_d = (BYTE_DATA == csum_q) ? StRun : StErr;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign BYTE_READY   = byte_ready;
  assign IMEM_WE      = we_q;
  assign IMEM_ADDR    = addr_q;
  assign IMEM_WDATA   = wdata_q;
  assign CORE_RESET_N = (state_q == StRun);
  assign DONE         = (state_q == StRun);
  assign ERROR        = (state_q == StErr);

endmodule
